mem_copy_engine: RTL and testbench
==================================

MEM_COPY_ENGINE -- requirements
Module: mem_copy_engine

Interface
REQ-001 Parameters: AW, default 10, word address width.
REQ-002 Parameters: DW, default 8, data width.
REQ-003 Parameters: LW, default AW+1, length and count width.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 start  input  1  copy request; sampled only in IDLE.
REQ-007 abort  input  1  stop request; honoured at word boundaries.
REQ-008 src_addr  input  AW  first source word address.
REQ-009 dst_addr  input  AW  first destination word address.
REQ-010 len  input  LW  word count, 0..2^AW.
REQ-011 busy  output  1  high while a copy is in progress.
REQ-012 done  output  1  one-cycle completion pulse.
REQ-013 aborted  output  1  qualifies done; high when the copy ended by abort.
REQ-014 words_done  output  LW  words written by the current or last copy.
REQ-015 mem_wen  output  1  memory write enable.
REQ-016 mem_addr  output  AW  memory address; upper 2 bits select the bank, lower AW-2 bits index within it.
REQ-017 mem_wdata  output  DW  memory write data.
REQ-018 mem_rdata  input  DW  memory read data, combinational from mem_addr in the same cycle.

Function
REQ-019 FSM states: IDLE, RD, WR, FIN; encoding is free; all outputs are registered or decoded from state and registers only.
REQ-020 IDLE: if start=1 at the edge and len!=0, latch src_addr, dst_addr and len, clear the index and words_done, go to RD; if start=1 and len=0, go to FIN with no memory access.
REQ-021 RD: mem_addr=src+idx, mem_wen=0; at the edge capture mem_rdata into a hold register, go to WR.
REQ-022 WR: mem_addr=dst+idx, mem_wdata=hold register, mem_wen=1; at the edge increment idx and words_done.
REQ-023 WR exit: go to FIN if the incremented idx equals len or abort=1; otherwise go to RD.
REQ-024 FIN: done=1 for exactly one cycle, busy=0, then go to IDLE; a start seen in FIN is ignored.
REQ-025 Timing: each word takes exactly 2 cycles (RD then WR); a len=N copy has busy high for 2N cycles, and done follows in the next cycle.
REQ-026 Address arithmetic is modulo 2^AW, so addresses wrap from 1023 to 0 and crossing a bank boundary needs no special handling.
REQ-027 Words copy in ascending index order with no overlap correction: with dst in (src, src+len), previously written values propagate, and this is the defined behaviour.
REQ-028 abort in RD is deferred; the current word completes its WR and the copy then terminates.
REQ-029 abort in IDLE or FIN has no effect.
REQ-030 aborted is set on the abort exit, cleared on the next accepted start, and otherwise held.
REQ-031 start while busy=1 is ignored; the latched parameters do not change mid-copy.
REQ-032 mem_wen is 0 in every state except WR.
REQ-033 mem_addr and mem_wdata are don't-care when mem_wen=0, except in RD as defined in REQ-021.
REQ-034 words_done holds its final value in IDLE until the next accepted start.

Reset
REQ-035 rst_n=0 forces the following immediately, without waiting for a clock: state=IDLE, busy=0, done=0, aborted=0, words_done=0, mem_wen=0, mem_addr=0, mem_wdata=0, hold register=0.
REQ-036 Reset mid-copy abandons the copy with no done pulse; words already written stay in memory and no partial write is issued.
REQ-037 The first start is accepted at the first rising edge after rst_n deasserts.

Verification
REQ-038 Memory preloaded with bank0[0..3]={11,22,33,44}; start with src=0, dst=0x200, len=4 -> bank2[0..3]={11,22,33,44}, busy high for 8 cycles, done in cycle 9, words_done=4, aborted=0.
REQ-039 Wrap: src=0x3FE, dst=0x0FE, len=4 -> source words at addresses 0x3FE, 0x3FF, 0x000, 0x001 land at 0x0FE, 0x0FF, 0x100, 0x101, crossing from bank0 into bank1.
REQ-040 len=0 -> no mem_wen pulse, done exactly one cycle after the start edge, words_done=0.
REQ-041 len=10 with abort pulsed in the 5th RD cycle -> exactly 5 writes, done with aborted=1, words_done=5.
REQ-042 Overlap: src=0x010, dst=0x011, len=3, memory[0x010]=0xA5 -> memory[0x011..0x013] all 0xA5; start pulsed during the copy has no effect.
REQ-043 rst_n low during the 3rd WR -> all outputs zero asynchronously, no done pulse, and a new start after release runs normally.
REQ-044 The bench pairs this block with the banked memory and a shadow-model scoreboard, and asserts mem_wen is 0 outside WR.

Source files
------------

// File: rtl/mem_copy_engine.sv
// ============================================================================
// Module  : mem_copy_engine
// Purpose : Word-by-word memory copy (read then write), abortable at word boundaries.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module mem_copy_engine #(
    parameter int AW = 10,
    parameter int DW = 8,
    parameter int LW = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic [AW-1:0] src_addr,
    input  logic [AW-1:0] dst_addr,
    input  logic [LW-1:0] len,
    output logic          busy,
    output logic          done,
    output logic          aborted,
    output logic [LW-1:0] words_done,
    output logic          mem_wen,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    localparam logic [LW-1:0] C_ONE  = LW'(1);
    localparam logic [LW-1:0] C_ZERO = '0;

    state_t        state_q, state_d;
    logic [AW-1:0] src_q, src_d;
    logic [AW-1:0] dst_q, dst_d;
    logic [LW-1:0] len_q, len_d;
    logic [LW-1:0] idx_q, idx_d;
    logic [LW-1:0] words_q, words_d;
    logic [DW-1:0] hold_q, hold_d;
    logic          aborted_q, aborted_d;
    logic          pend_q, pend_d;
    logic [LW-1:0] w_idx_inc;

    assign w_idx_inc = idx_q + C_ONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            src_q     <= '0;
            dst_q     <= '0;
            len_q     <= '0;
            idx_q     <= '0;
            words_q   <= '0;
            hold_q    <= '0;
            aborted_q <= 1'b0;
            pend_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            words_q   <= words_d;
            hold_q    <= hold_d;
            aborted_q <= aborted_d;
            pend_q    <= pend_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        dst_d     = dst_q;
        len_d     = len_q;
        idx_d     = idx_q;
        words_d   = words_q;
        hold_d    = hold_q;
        aborted_d = aborted_q;
        pend_d    = pend_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    src_d     = src_addr;
                    dst_d     = dst_addr;
                    len_d     = len;
                    idx_d     = '0;
                    words_d   = '0;
                    aborted_d = 1'b0;
                    pend_d    = 1'b0;
                    state_d   = (len != C_ZERO) ? S_RD : S_FIN;
                end
            end
            S_RD: begin
                hold_d = mem_rdata;
                // An abort seen during the read is remembered so the word still completes
                if (abort) pend_d = 1'b1;
                state_d = S_WR;
            end
            S_WR: begin
                idx_d   = w_idx_inc;
                words_d = words_q + C_ONE;
                if ((w_idx_inc == len_q) || abort || pend_q) begin
                    aborted_d = abort | pend_q;
                    pend_d    = 1'b0;
                    state_d   = S_FIN;
                end else begin
                    state_d = S_RD;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mem_addr = '0;
        case (state_q)
            S_RD:    mem_addr = src_q + idx_q[AW-1:0];
            S_WR:    mem_addr = dst_q + idx_q[AW-1:0];
            default: mem_addr = '0;
        endcase
    end

    assign busy       = (state_q == S_RD) || (state_q == S_WR);
    assign done       = (state_q == S_FIN);
    assign mem_wen    = (state_q == S_WR);
    assign mem_wdata  = hold_q;
    assign aborted    = aborted_q;
    assign words_done = words_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_copy_engine.sv
// ============================================================================
// Module  : tb_mem_copy_engine
// Purpose : Directed bench: banked memory, shadow model and write scoreboard.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_mem_copy_engine;
    localparam int AW = 10;
    localparam int DW = 8;
    localparam int LW = 11;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [AW-1:0] src_addr = '0;
    logic [AW-1:0] dst_addr = '0;
    logic [LW-1:0] len = '0;
    logic          busy, done, aborted, mem_wen;
    logic [LW-1:0] words_done;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    logic [DW-1:0] bank [4][256];
    logic [DW-1:0] shadow [1024];
    wr_t           exp_q[$];
    int            n_vec = 0;
    int            n_err = 0;
    logic          prev_wen = 1'b0;

    always #5 clk = ~clk;

    mem_copy_engine #(.AW(AW), .DW(DW), .LW(LW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
        .busy(busy), .done(done), .aborted(aborted), .words_done(words_done),
        .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    assign mem_rdata = bank[mem_addr[AW-1:AW-2]][mem_addr[AW-3:0]];

    function automatic logic [DW-1:0] init_val(input int a);
        case (a)
            0:       return 8'd11;
            1:       return 8'd22;
            2:       return 8'd33;
            3:       return 8'd44;
            16:      return 8'hA5;
            default: return 8'((a * 37 + 5) & 255);
        endcase
    endfunction

    initial begin : memory
        for (int a = 0; a < 1024; a++) bank[2'(a >> 8)][8'(a)] <= init_val(a);
        forever begin
            @(posedge clk);
            if (mem_wen) bank[mem_addr[AW-1:AW-2]][mem_addr[AW-3:0]] <= mem_wdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Every write the DUT issues must match the head of the scoreboard
    always @(negedge clk) begin
        if (mem_wen) begin
            wr_t e;
            check("wen_only_while_busy", 32'(busy), 32'd1);
            check("wen_not_back_to_back", 32'(prev_wen), 32'd0);
            n_vec++;
            assert (exp_q.size() != 0) else begin
                n_err++;
                $error("FAIL unexpected_write: observed write addr %0h data %0h expected none",
                       mem_addr, mem_wdata);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("write_addr", 32'(mem_addr), 32'(e.a));
                check("write_data", 32'(mem_wdata), 32'(e.d));
            end
        end
        prev_wen = mem_wen;
    end

    task automatic push_exp(input logic [AW-1:0] s, input logic [AW-1:0] d, input int n);
        for (int i = 0; i < n; i++) begin
            logic [AW-1:0] sa, da;
            logic [DW-1:0] v;
            sa = s + AW'(i);
            da = d + AW'(i);
            v  = shadow[sa];
            shadow[da] = v;
            exp_q.push_back('{a: da, d: v});
        end
    endtask

    task automatic run_copy(input logic [AW-1:0] s, input logic [AW-1:0] d,
                            input logic [LW-1:0] n, input int abort_rd, input bit mid_start,
                            input int exp_words, input logic exp_ab, input string tag);
        int cyc, busy_cnt;
        bit got_done;
        push_exp(s, d, exp_words);
        @(posedge clk); #1;
        src_addr = s; dst_addr = d; len = n; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0; busy_cnt = 0; got_done = 1'b0;
        while (!got_done && cyc < 3000) begin
            abort = (abort_rd > 0) && (cyc == 2 * (abort_rd - 1));
            if (mid_start && cyc == 2) begin
                start = 1'b1; src_addr = 10'h3C0; dst_addr = 10'h0C0; len = 11'd7;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) got_done = 1'b1;
            else begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        abort = 1'b0; start = 1'b0;
        check({tag, "_done_seen"}, 32'(got_done), 32'd1);
        check({tag, "_done_cycle"}, 32'(cyc), 32'(2 * exp_words));
        check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(2 * exp_words));
        check({tag, "_busy_in_fin"}, 32'(busy), 32'd0);
        check({tag, "_words_done"}, 32'(words_done), 32'(exp_words));
        check({tag, "_aborted"}, 32'(aborted), 32'(exp_ab));
        check({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
        @(posedge clk); #1;
        check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
        check({tag, "_words_held"}, 32'(words_done), 32'(exp_words));
    endtask

    initial begin : stim
        int diffs;
        for (int a = 0; a < 1024; a++) shadow[a] = init_val(a);
        rst_n = 1'b0;
        #2;
        check("rst_ctrl", {29'd0, busy, done, aborted}, 32'd0);
        check("rst_words_done", 32'(words_done), 32'd0);
        check("rst_mem_bus", {13'd0, mem_wen, mem_addr, mem_wdata}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Plain copy bank0 -> bank2
        run_copy(10'h000, 10'h200, 11'd4, 0, 1'b0, 4, 1'b0, "basic");
        for (int i = 0; i < 4; i++) check("basic_bank2", 32'(bank[2][i]), 32'(init_val(i)));

        // Address wrap 0x3FF->0x000 and bank0->bank1 crossing
        run_copy(10'h3FE, 10'h0FE, 11'd4, 0, 1'b0, 4, 1'b0, "wrap");
        check("wrap_0x100", 32'(bank[1][0]), 32'(init_val(0)));

        run_copy(10'h050, 10'h060, 11'd0, 0, 1'b0, 0, 1'b0, "len0");

        run_copy(10'h020, 10'h220, 11'd10, 5, 1'b0, 5, 1'b1, "abort");
        repeat (3) @(posedge clk);
        #1 check("aborted_held", 32'(aborted), 32'd1);

        run_copy(10'h010, 10'h011, 11'd3, 0, 1'b1, 3, 1'b0, "overlap");
        for (int i = 1; i <= 3; i++) check("overlap_a5", 32'(bank[0][i + 16]), 32'hA5);

        // Reset during the third write of a 6-word copy
        push_exp(10'h040, 10'h300, 2);
        @(posedge clk); #1;
        src_addr = 10'h040; dst_addr = 10'h300; len = 11'd6; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1 check("wr3_wen_before_rst", 32'(mem_wen), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_ctrl", {29'd0, busy, done, aborted}, 32'd0);
        check("midrst_words_done", 32'(words_done), 32'd0);
        check("midrst_mem_bus", {13'd0, mem_wen, mem_addr, mem_wdata}, 32'd0);
        repeat (2) begin
            @(negedge clk);
            check("midrst_no_done", 32'(done), 32'd0);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        check("midrst_sb_empty", 32'(exp_q.size()), 32'd0);
        run_copy(10'h100, 10'h380, 11'd3, 0, 1'b0, 3, 1'b0, "post_rst");

        diffs = 0;
        for (int a = 0; a < 1024; a++)
            if (bank[2'(a >> 8)][8'(a)] !== shadow[a]) diffs++;
        check("memory_vs_shadow_diffs", 32'(diffs), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
